// File: rtl/load_store_unit_if.sv
// Request/response and memory-side signal bundle for load_store_unit.
// Ports: req_* (core request), rsp_* (response pulse), mem_* (word memory).
// slave = the load/store unit itself; master = core + memory environment.
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;

  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  logic [31:0] mem_address;
  logic [31:0] mem_data_out;
  logic [31:0] mem_data_in;
  logic        mem_we;

  modport slave (
    input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_in,
    output req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_out, mem_we
  );

  modport master (
    output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata, mem_data_in,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err, mem_address, mem_data_out, mem_we
  );
endinterface

// File: rtl/load_store_unit.sv
// Load/store unit: turns byte/half/word requests into 32-bit word accesses,
// using read-modify-write for sub-word stores (memory has no byte enables).
// Latency: error 1, load 2, word store 2, sub-word store 3 cycles; one request in flight, no rsp back-pressure.
// Ports: clk, resetn (async active-low), bus (slave modport: req_*, rsp_*, mem_*).
module load_store_unit #(
  parameter logic [31:0] BASE_ADDR = 32'h0000_0000,
  parameter int unsigned MEM_BYTES = 16384
) (
  input  logic               clk,
  input  logic               resetn,
  load_store_unit_if.slave   bus
);

  localparam logic [31:0] MEM_LIMIT = 32'(MEM_BYTES);

  typedef enum logic [1:0] {IDLE, READ, WRITE, RESP} state_e;

  state_e      state_q, state_d;
  logic [31:0] addr_q,  addr_d;
  logic [1:0]  size_q,  size_d;
  logic        we_q,    we_d;
  logic        uns_q,   uns_d;
  logic [15:0] wdata_q, wdata_d;   // only the sub-word lane is needed after accept
  logic [31:0] rdata_q, rdata_d;
  logic        err_q,   err_d;
  logic [31:0] mdata_q, mdata_d;

  logic [31:0] req_off;
  logic        req_err;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] load_val;
  logic [31:0] merged;

  // Range check is done on the offset so a window that wraps past 0 still works.
  assign req_off = bus.req_addr - BASE_ADDR;
  assign req_err = (bus.req_size == 2'b11)
                 | ((bus.req_size == 2'b01) & bus.req_addr[0])
                 | ((bus.req_size == 2'b10) & (bus.req_addr[1:0] != 2'b00))
                 | (req_off >= MEM_LIMIT);

  // Lane extraction for loads and lane merge for sub-word stores.
  always_comb begin
    lane_b   = 8'h00;
    load_val = bus.mem_data_in;
    merged   = bus.mem_data_in;
    case (addr_q[1:0])
      2'd0:    lane_b = bus.mem_data_in[7:0];
      2'd1:    lane_b = bus.mem_data_in[15:8];
      2'd2:    lane_b = bus.mem_data_in[23:16];
      default: lane_b = bus.mem_data_in[31:24];
    endcase
    lane_h = addr_q[1] ? bus.mem_data_in[31:16] : bus.mem_data_in[15:0];
    case (size_q)
      2'b00: begin
        load_val = uns_q ? {24'h0, lane_b} : {{24{lane_b[7]}}, lane_b};
        case (addr_q[1:0])
          2'd0:    merged[7:0]   = wdata_q[7:0];
          2'd1:    merged[15:8]  = wdata_q[7:0];
          2'd2:    merged[23:16] = wdata_q[7:0];
          default: merged[31:24] = wdata_q[7:0];
        endcase
      end
      2'b01: begin
        load_val = uns_q ? {16'h0, lane_h} : {{16{lane_h[15]}}, lane_h};
        if (addr_q[1]) merged[31:16] = wdata_q;
        else           merged[15:0]  = wdata_q;
      end
      default: ;
    endcase
  end

  always_comb begin
    state_d = state_q;
    addr_d  = addr_q;
    size_d  = size_q;
    we_d    = we_q;
    uns_d   = uns_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    mdata_d = mdata_q;
    case (state_q)
      IDLE: begin
        if (bus.req_valid) begin
          addr_d  = bus.req_addr;
          size_d  = bus.req_size;
          we_d    = bus.req_we;
          uns_d   = bus.req_unsigned;
          wdata_d = bus.req_wdata[15:0];
          rdata_d = 32'h0;             // stores and errors report zero data
          err_d   = req_err;
          if (req_err) begin
            state_d = RESP;
          end else if (bus.req_we && (bus.req_size == 2'b10)) begin
            mdata_d = bus.req_wdata;
            state_d = WRITE;
          end else begin
            state_d = READ;
          end
        end
      end
      READ: begin
        if (we_q) begin
          mdata_d = merged;
          state_d = WRITE;
        end else begin
          rdata_d = load_val;
          state_d = RESP;
        end
      end
      WRITE:   state_d = RESP;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      addr_q  <= 32'h0;
      size_q  <= 2'b00;
      we_q    <= 1'b0;
      uns_q   <= 1'b0;
      wdata_q <= 16'h0;
      rdata_q <= 32'h0;
      err_q   <= 1'b0;
      mdata_q <= 32'h0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
      size_q  <= size_d;
      we_q    <= we_d;
      uns_q   <= uns_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      mdata_q <= mdata_d;
    end
  end

  // Strobes decode straight from the state register, so reset drops mem_we asynchronously.
  assign bus.req_ready    = (state_q == IDLE);
  assign bus.rsp_valid    = (state_q == RESP);
  assign bus.mem_we       = (state_q == WRITE);
  assign bus.rsp_rdata    = rdata_q;
  assign bus.rsp_err      = err_q;
  assign bus.mem_address  = {addr_q[31:2], 2'b00};
  assign bus.mem_data_out = mdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit: a byte-array reference model predicts each
// response at issue time; a negedge monitor checks responses, memory writes and latency.
module tb_load_store_unit;

  localparam logic [31:0] BASE = 32'h0000_0000;
  localparam int          MBYTES = 16384;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  load_store_unit_if bus();

  load_store_unit #(.BASE_ADDR(BASE), .MEM_BYTES(MBYTES)) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  // Word memory seen by the DUT.
  logic [31:0] mem [MBYTES/4];
  assign bus.mem_data_in = mem[bus.mem_address[13:2]];
  always @(posedge clk) if (bus.mem_we) mem[bus.mem_address[13:2]] <= bus.mem_data_out;

  // Reference model state: plain byte array.
  logic [7:0] ref_mem [MBYTES];

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nwe;
    logic [31:0] wword;
    logic [31:0] waddr;
    int          acc;
  } sb_t;

  sb_t q[$];
  int  cyc = 0;
  int  nvec = 0;
  int  nerr = 0;
  int  we_seen = 0;
  bit  prev_rsp = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic sb_t model(input bit we, input logic [1:0] sz, input bit uns,
                                input logic [31:0] a, input logic [31:0] wd);
    sb_t e;
    int n, idx, base;
    logic [31:0] v;
    e.rdata = 32'h0; e.nwe = 0; e.wword = 32'h0; e.acc = 0;
    e.waddr = {a[31:2], 2'b00};
    e.err = (sz == 2'd3) || (sz == 2'd1 && a[0]) || (sz == 2'd2 && a[1:0] != 2'b00)
            || ((a - BASE) >= 32'(MBYTES));
    if (e.err) begin
      e.lat = 1;
      return e;
    end
    n   = 1 << sz;
    idx = int'(a - BASE);
    if (!we) begin
      v = 32'h0;
      for (int i = 0; i < n; i++) v[8*i +: 8] = ref_mem[idx + i];
      if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8*n));
      e.rdata = v;
      e.lat = 2;
    end else begin
      for (int i = 0; i < n; i++) ref_mem[idx + i] = wd[8*i +: 8];
      base = idx & ~3;
      for (int i = 0; i < 4; i++) e.wword[8*i +: 8] = ref_mem[base + i];
      e.nwe = 1;
      e.lat = (n == 4) ? 2 : 3;
    end
    return e;
  endfunction

  // Issue one request. use_lit replaces the predicted load data (or written word for stores)
  // with a literal; abort issues without predicting anything (used for the reset case).
  task automatic issue(input bit we, input logic [1:0] sz, input bit uns, input logic [31:0] a,
                       input logic [31:0] wd, input bit use_lit, input logic [31:0] lit,
                       input bit abort);
    sb_t e;
    int t;
    t = 0;
    @(negedge clk);
    while (!bus.req_ready && t < 30) begin
      @(negedge clk);
      t++;
    end
    if (!bus.req_ready) begin
      chk("ready_timeout", {31'h0, bus.req_ready}, 32'h1);
      return;
    end
    e = '{default: 0};
    if (!abort) begin
      e = model(we, sz, uns, a, wd);
      if (use_lit && !e.err) begin
        if (we) e.wword = lit;
        else    e.rdata = lit;
      end
    end
    bus.req_valid    = 1'b1;
    bus.req_we       = we;
    bus.req_size     = sz;
    bus.req_unsigned = uns;
    bus.req_addr     = a;
    bus.req_wdata    = wd;
    @(posedge clk);
    #1;
    e.acc = cyc;
    if (!abort) q.push_back(e);
    bus.req_valid = 1'b0;
  endtask

  task automatic drain();
    int t;
    t = 0;
    while (q.size() != 0 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (q.size() != 0) begin
      chk("drain_timeout", q.size(), 32'h0);
      q.delete();
    end
  endtask

  // Monitor: responses, memory writes, latency and ready-after-response.
  always @(negedge clk) begin
    sb_t e;
    if (bus.mem_we) begin
      we_seen++;
      if (q.size() == 0) chk("unexpected_mem_we", 32'h1, 32'h0);
      else begin
        chk("mem_data_out", bus.mem_data_out, q[0].wword);
        chk("mem_address", bus.mem_address, q[0].waddr);
      end
    end
    if (resetn) begin
      if (prev_rsp) chk("ready_after_rsp", {31'h0, bus.req_ready}, 32'h1);
      prev_rsp = bus.rsp_valid;
      if (bus.rsp_valid) begin
        if (q.size() == 0) chk("unexpected_rsp", 32'h1, 32'h0);
        else begin
          e = q.pop_front();
          chk("rsp_rdata", bus.rsp_rdata, e.rdata);
          chk("rsp_err", {31'h0, bus.rsp_err}, {31'h0, e.err});
          chk("latency", cyc + 1 - e.acc, e.lat);
          chk("mem_we_count", we_seen, e.nwe);
        end
        we_seen = 0;
      end
    end else begin
      prev_rsp = 1'b0;
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    logic [31:0] w, a;
    logic [1:0]  sz;
    bit          we, uns;

    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;

    for (int i = 0; i < MBYTES/4; i++) begin
      w = (i == 32'h40) ? 32'h8899_AABB : $urandom;
      mem[i] = w;
      for (int b = 0; b < 4; b++) ref_mem[4*i + b] = w[8*b +: 8];
    end

    // Reset state.
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_req_ready", {31'h0, bus.req_ready}, 32'h1);
    chk("rst_rsp_valid", {31'h0, bus.rsp_valid}, 32'h0);
    chk("rst_mem_we", {31'h0, bus.mem_we}, 32'h0);
    chk("rst_mem_address", bus.mem_address, 32'h0);
    chk("rst_mem_data_out", bus.mem_data_out, 32'h0);
    chk("rst_rsp_rdata", bus.rsp_rdata, 32'h0);
    chk("rst_rsp_err", {31'h0, bus.rsp_err}, 32'h0);
    resetn = 1'b1;

    // Directed cases.
    issue(0, 2'd0, 0, 32'h101, 32'h0, 1, 32'hFFFF_FFAA, 0);
    issue(0, 2'd1, 1, 32'h102, 32'h0, 1, 32'h0000_8899, 0);
    issue(0, 2'd1, 0, 32'h102, 32'h0, 1, 32'hFFFF_8899, 0);
    issue(1, 2'd0, 0, 32'h103, 32'h1234_5677, 1, 32'h7799_AABB, 0);
    issue(0, 2'd2, 0, 32'h100, 32'h0, 1, 32'h7799_AABB, 0);
    issue(1, 2'd2, 0, 32'h200, 32'hDEAD_BEEF, 1, 32'hDEAD_BEEF, 0);
    issue(0, 2'd2, 0, 32'h200, 32'h0, 1, 32'hDEAD_BEEF, 0);
    issue(1, 2'd1, 0, 32'h101, 32'h0000_FFFF, 0, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h4002, 32'h0, 0, 32'h0, 0);
    issue(0, 2'd3, 0, 32'h0, 32'h0, 0, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h3FFC, 32'h0, 0, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h4000, 32'h0, 0, 32'h0, 0);
    issue(1, 2'd1, 0, 32'h3FFE, 32'hCAFE_F00D, 0, 32'h0, 0);
    issue(0, 2'd2, 0, 32'h3FFC, 32'h0, 0, 32'h0, 0);

    // Randomised traffic concentrated on a small window so stores are re-read.
    for (int n = 0; n < 300; n++) begin
      we  = $urandom_range(0, 1);
      uns = $urandom_range(0, 1);
      sz  = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      if ($urandom_range(0, 9) == 0)
        a = ($urandom_range(0, 1) == 0) ? 32'h4000 + $urandom_range(0, 4095) : 32'hFFFF_FFFC;
      else
        a = 32'h100 + $urandom_range(0, 63);
      if ($urandom_range(0, 3) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      issue(we, sz, uns, a, $urandom, 0, 32'h0, 0);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    // Reset during READ of a byte store: no write, no response, word unchanged.
    drain();
    issue(1, 2'd0, 0, 32'h104, 32'h0000_00AB, 0, 32'h0, 1);
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    resetn = 1'b1;
    #1;
    chk("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);
    chk("abort_mem_we", we_seen, 32'h0);
    repeat (4) @(negedge clk);
    issue(0, 2'd2, 0, 32'h104, 32'h0, 0, 32'h0, 0);
    issue(0, 2'd0, 1, 32'h104, 32'h0, 0, 32'h0, 0);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
